// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: turns dual-rail P/N symbols back into NRZ data.
// It strips 000V/B00V substitutions through a 4-symbol delay line and flags line-code errors.
module hdb3_decoder #(
    parameter bit ZRUN_CHK = 1'b1,
    parameter bit VALT_CHK = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic in_p,
    input  logic in_n,
    output logic data_out,
    output logic data_valid,
    output logic code_err
);

    logic [3:0] sr_q, sr_d;
    logic [2:0] fill_q, fill_d;
    logic [2:0] zrun_q, zrun_d;
    logic       seen_mark_q, seen_mark_d;
    logic       last_pol_q, last_pol_d;
    logic       seen_v_q, seen_v_d;
    logic       last_v_pol_q, last_v_pol_d;
    logic       data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       code_err_q, code_err_d;

    logic mark_s, pol_s, illegal_s, is_v_s, v_err_s, z_err_s;

    assign mark_s    = in_p ^ in_n;
    assign pol_s     = in_n;
    assign illegal_s = in_p & in_n;
    // A V repeats the polarity of the previous mark; the first mark can never be one.
    assign is_v_s    = mark_s & seen_mark_q & (pol_s == last_pol_q);
    assign v_err_s   = VALT_CHK & is_v_s & seen_v_q & (pol_s == last_v_pol_q);
    // Flag only the space that brings the run to four, so a long run gives one pulse.
    assign z_err_s   = ZRUN_CHK & ~mark_s & (zrun_q == 3'd3);

    // Next-state logic: everything advances only on a symbol strobe.
    always_comb begin
        sr_d         = sr_q;
        fill_d       = fill_q;
        zrun_d       = zrun_q;
        seen_mark_d  = seen_mark_q;
        last_pol_d   = last_pol_q;
        seen_v_d     = seen_v_q;
        last_v_pol_d = last_v_pol_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        code_err_d   = 1'b0;
        if (bit_en) begin
            data_out_d   = sr_q[3];
            data_valid_d = (fill_q == 3'd4);
            code_err_d   = illegal_s | v_err_s | z_err_s;
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end else begin
                fill_d = fill_q;
            end
            // A V cancels itself and the three positions before it (000V or B00V).
            if (is_v_s) begin
                sr_d         = 4'b0000;
                seen_v_d     = 1'b1;
                last_v_pol_d = pol_s;
            end else begin
                sr_d = {sr_q[2:0], mark_s};
            end
            if (mark_s) begin
                seen_mark_d = 1'b1;
                last_pol_d  = pol_s;
                zrun_d      = 3'd0;
            end else if (zrun_q != 3'd4) begin
                zrun_d = zrun_q + 3'd1;
            end else begin
                zrun_d = zrun_q;
            end
        end else begin
            data_out_d = data_out_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q         <= 4'b0000;
            fill_q       <= 3'd0;
            zrun_q       <= 3'd0;
            seen_mark_q  <= 1'b0;
            last_pol_q   <= 1'b0;
            seen_v_q     <= 1'b0;
            last_v_pol_q <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            zrun_q       <= zrun_d;
            seen_mark_q  <= seen_mark_d;
            last_pol_q   <= last_pol_d;
            seen_v_q     <= seen_v_d;
            last_v_pol_q <= last_v_pol_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            code_err_q   <= code_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign code_err   = code_err_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: directed symbol strings with hand-decoded expectations.
// A monitor pops expected bits on data_valid and expected error flags after each strobe.
module tb_hdb3_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0;
    logic in_p = 1'b0;
    logic in_n = 1'b0;
    logic data_out, data_valid, code_err;

    int n_cmp = 0;
    int n_bad = 0;
    int strobes = 0;
    int dv_streak = 0;
    int dv_max = 0;
    logic exp_data_q[$];
    logic exp_err_q[$];

    hdb3_decoder #(.ZRUN_CHK(1'b1), .VALT_CHK(1'b1)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .in_p(in_p), .in_n(in_n),
        .data_out(data_out), .data_valid(data_valid), .code_err(code_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs 1 time unit after each rising edge.
    initial begin
        logic had;
        logic e;
        forever begin
            @(posedge clk);
            had = bit_en && !rst;
            #1;
            if (data_valid) begin
                dv_streak++;
                if (dv_streak > dv_max) dv_max = dv_streak;
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_data_valid", 1, 0);
                end else begin
                    e = exp_data_q.pop_front();
                    chk("data_out", int'(data_out), int'(e));
                end
            end else begin
                dv_streak = 0;
            end
            if (had) begin
                if (exp_err_q.size() == 0) begin
                    chk("err_queue_underflow", 1, 0);
                end else begin
                    e = exp_err_q.pop_front();
                    chk("code_err_strobe", int'(code_err), int'(e));
                end
            end else begin
                chk("code_err_idle", int'(code_err), 0);
            end
        end
    end

    // Bits still inside the delay line at reset never come out.
    task automatic drop_pending();
        int n;
        n = (strobes < 4) ? strobes : 4;
        for (int i = 0; i < n; i++) begin
            if (exp_data_q.size() > 0) void'(exp_data_q.pop_back());
        end
        strobes = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_code_err", int'(code_err), 0);
        drop_pending();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seq(input string s, input string d, input string e, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            case (s[i])
                "P":     begin in_p = 1'b1; in_n = 1'b0; end
                "N":     begin in_p = 1'b0; in_n = 1'b1; end
                "X":     begin in_p = 1'b1; in_n = 1'b1; end
                default: begin in_p = 1'b0; in_n = 1'b0; end
            endcase
            bit_en = 1'b1;
            exp_data_q.push_back(d[i] == "1");
            exp_err_q.push_back(e[i] == "1");
            strobes++;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bit_en = 1'b0;
            end
        end
        @(negedge clk);
        bit_en = 1'b0;
        in_p = 1'b0;
        in_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("init_data_out", int'(data_out), 0);
        chk("init_data_valid", int'(data_valid), 0);
        chk("init_code_err", int'(code_err), 0);
        rst = 1'b0;

        // Plain AMI, no substitutions.
        run_seq("PZNZPNPNPN", "1010111111", "0000000000", 1);
        do_reset();
        // 000V.
        run_seq("PZZZPNPNPN", "1000011111", "0000000000", 1);
        do_reset();
        // B00V.
        run_seq("PNZZNPNPNP", "1000011111", "0000000000", 2);
        do_reset();
        // Illegal symbol, then a five-space run.
        run_seq("PNXPNZZZZZPNPNP", "110110000011111", "001000001000000", 1);
        do_reset();
        // Two positive V pulses in a row.
        run_seq("PZZZPZZZPNPNP", "1000000001111", "0000000010000", 1);
        do_reset();
        // Reset with sr=1011 queued, then bit_en held high.
        run_seq("PNPNPZNP", "11111011", "00000000", 0);
        chk("pre_rst_data_out", int'(data_out), 1);
        do_reset();
        dv_max = 0;
        run_seq("PNPNPNPNPN", "1111111111", "0000000000", 0);
        repeat (3) @(negedge clk);
        chk("held_high_dv_run", dv_max, 6);

        drop_pending();
        repeat (10) @(negedge clk);
        chk("data_queue_left", exp_data_q.size(), 0);
        chk("err_queue_left", exp_err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
